// File: rtl/puf_seq_pkg.sv
// Shared constants and FSM encoding for the PUF response sequencer.
package puf_seq_pkg;

  localparam int unsigned RespWDefault   = 8;
  localparam int unsigned TimeoutDefault = 1023;
  localparam int unsigned ChallW         = 8;
  localparam int unsigned TmoW           = 16;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StRun,
    StDone
  } puf_state_e;

endpackage

// File: rtl/puf_seq_if.sv
// Request/response and PUF-cell signals between the sequencer and its surroundings.
interface puf_seq_if
  import puf_seq_pkg::*;
#(
  parameter int unsigned RESP_W = RespWDefault
);

  logic              start;
  logic [ChallW-1:0] seed;
  logic [ChallW-1:0] puf_chall;
  logic              puf_en;
  logic              puf_clr;
  logic              puf_resp;
  logic              puf_finish;
  logic              busy;
  logic [RESP_W-1:0] resp;
  logic              valid;
  logic              err;

  modport slave (
    input  start, seed, puf_resp, puf_finish,
    output puf_chall, puf_en, puf_clr, busy, resp, valid, err
  );

  modport master (
    output start, seed, puf_resp, puf_finish,
    input  puf_chall, puf_en, puf_clr, busy, resp, valid, err
  );

endinterface

// File: rtl/puf_timeout.sv
// Per-bit RUN-cycle counter; expired_o flags the last permitted RUN cycle.
module puf_timeout
  import puf_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TmoW-1:0] LastCnt = TmoW'(TIMEOUT - 1);

  logic [TmoW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter would reach TIMEOUT at this edge.
  assign expired_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/puf_seq.sv
// Sequencer that clears, runs and samples a PUF bit cell once per response bit.
module puf_seq
  import puf_seq_pkg::*;
#(
  parameter int unsigned RESP_W  = RespWDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic      clk,
  input  logic      rst_n,
  puf_seq_if.slave  puf_bus
);

  localparam int unsigned    IdxW    = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(RESP_W - 1);

  puf_state_e        state_q;
  logic [ChallW-1:0] chall_q;
  logic [IdxW-1:0]   idx_q;
  logic [RESP_W-1:0] resp_q;
  logic              err_q;
  logic              en_q;
  logic              clr_q;
  logic              busy_q;
  logic              valid_q;

  logic run, expired, capture, accept, tmo_clr;

  assign run     = (state_q == StRun);
  assign accept  = (state_q == StIdle) && puf_bus.start;
  // Finish wins over a simultaneous expiry.
  assign capture = run && (puf_bus.puf_finish || expired);
  assign tmo_clr = accept || capture;

  puf_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (tmo_clr),
    .en_i      (run),
    .expired_o (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      chall_q <= '0;
      idx_q   <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (puf_bus.start) begin
            chall_q <= puf_bus.seed;
            idx_q   <= '0;
            resp_q  <= '0;
            err_q   <= 1'b0;
            clr_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StClear;
          end
        end
        StClear: begin
          clr_q   <= 1'b0;
          en_q    <= 1'b1;
          state_q <= StRun;
        end
        StRun: begin
          if (capture) begin
            resp_q[idx_q] <= puf_bus.puf_finish ? puf_bus.puf_resp : 1'b0;
            if (!puf_bus.puf_finish) begin
              err_q <= 1'b1;
            end
            en_q <= 1'b0;
            if (idx_q == LastIdx) begin
              valid_q <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + 1'b1;
              chall_q <= chall_q + 1'b1;
              clr_q   <= 1'b1;
              state_q <= StClear;
            end
          end
        end
        StDone: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign puf_bus.puf_chall = chall_q;
  assign puf_bus.puf_en    = en_q;
  assign puf_bus.puf_clr   = clr_q;
  assign puf_bus.busy      = busy_q;
  assign puf_bus.resp      = resp_q;
  assign puf_bus.valid     = valid_q;
  assign puf_bus.err       = err_q;

endmodule

// File: tb/tb_puf_seq.sv
// Directed bench for puf_seq with a behavioural PUF cell of programmable per-bit delay.
module tb_puf_seq;
  import puf_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  puf_seq_if #(.RESP_W(8)) bus ();

  puf_seq #(
    .RESP_W  (8),
    .TIMEOUT (15)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .puf_bus (bus)
  );

  // Cell model: finish on RUN cycle dly[b]+1 of bit b (never when dly < 0).
  int   dly [8];
  logic pat [8];
  int   run_cnt;
  int   clr_seen;
  int   bidx;

  always_comb bidx = (clr_seen > 0 && clr_seen <= 8) ? clr_seen - 1 : 0;

  assign bus.puf_finish = bus.puf_en && (dly[bidx] >= 0) && (run_cnt == dly[bidx]);
  assign bus.puf_resp   = pat[bidx];

  always @(posedge clk) begin
    if (bus.puf_clr) run_cnt <= 0;
    else if (bus.puf_en) run_cnt <= run_cnt + 1;
    if (bus.start && !bus.busy) clr_seen <= 0;
    else if (bus.puf_clr) clr_seen <= clr_seen + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] chq [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {8'h00, bus.puf_chall, bus.puf_en, bus.puf_clr, bus.busy, bus.valid, bus.err,
            3'b000, bus.resp};
  endfunction

  task automatic set_bits(input int d, input logic [7:0] p);
    for (int i = 0; i < 8; i++) begin
      dly[i] = d;
      pat[i] = p[i];
    end
  endtask

  // Issues one request; lat = edges from the start edge to the valid edge.
  task automatic run_req(input string tag, input logic [7:0] sd, input int inject,
                         output int lat, output int np);
    logic done;
    done = 1'b0;
    lat  = -1;
    np   = 0;
    chq.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.seed  = sd;
    @(negedge clk);
    for (int i = 1; i <= 400; i++) begin
      if (i == 1) check_eq({tag, "_clear_phase"}, 32'({bus.busy, bus.puf_clr, bus.puf_en}), 32'h6);
      if (i == 2) check_eq({tag, "_run_phase"}, 32'({bus.puf_clr, bus.puf_en}), 32'h1);
      if (bus.puf_clr) chq.push_back(bus.puf_chall);
      if (bus.valid) begin
        np++;
        if (lat < 0) lat = i - 1;
      end
      bus.start = (i == inject);
      bus.seed  = (i == inject) ? 8'h00 : 8'h55;
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_eq({tag, "_terminates"}, 32'(done), 32'd1);
  endtask

  int lat, np;

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.seed  = 8'h55;
    set_bits(5, 8'h00);
    repeat (3) @(negedge clk);
    check_eq("reset_outs", outs(), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_outs", outs(), 32'h0);

    // Nominal 8-bit collection.
    set_bits(5, 8'h4D);
    run_req("t1", 8'h3C, 0, lat, np);
    check_eq("t1_resp", 32'(bus.resp), 32'h4D);
    check_eq("t1_err", 32'(bus.err), 32'h0);
    check_eq("t1_latency", 32'(lat), 32'd56);
    check_eq("t1_valid_cnt", 32'(np), 32'd1);
    check_eq("t1_chall_n", 32'(chq.size()), 32'd8);
    check_eq("t1_chall_first", 32'(chq[0]), 32'h3C);
    check_eq("t1_chall_last", 32'(chq[7]), 32'h43);
    repeat (3) @(negedge clk);
    check_eq("t1_resp_hold", 32'({bus.busy, bus.resp}), 32'h04D);

    // Challenge wraps at 8'hFF.
    set_bits(2, 8'hFF);
    run_req("t2", 8'hFE, 0, lat, np);
    check_eq("t2_resp", 32'(bus.resp), 32'hFF);
    check_eq("t2_chall_wrap", {chq[0], chq[1], chq[2], chq[3]}, 32'hFEFF0001);

    // Bit 2 never finishes: timeout after 15 RUN cycles.
    set_bits(3, 8'hFF);
    dly[2] = -1;
    run_req("t3", 8'h80, 0, lat, np);
    check_eq("t3_resp", 32'(bus.resp), 32'hFB);
    check_eq("t3_err", 32'(bus.err), 32'h1);
    check_eq("t3_latency", 32'(lat), 32'd51);
    check_eq("t3_valid_cnt", 32'(np), 32'd1);

    // start with seed 0 while in RUN must be ignored.
    set_bits(1, 8'hAA);
    run_req("t4", 8'h10, 3, lat, np);
    check_eq("t4_resp", 32'(bus.resp), 32'hAA);
    check_eq("t4_err_cleared", 32'(bus.err), 32'h0);
    check_eq("t4_chall_first", 32'(chq[0]), 32'h10);
    check_eq("t4_chall_last", 32'(chq[7]), 32'h17);
    check_eq("t4_latency", 32'(lat), 32'd24);

    // Asynchronous reset during RUN of bit 3.
    set_bits(4, 8'hFF);
    @(negedge clk);
    bus.start = 1'b1;
    bus.seed  = 8'h20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (21) @(negedge clk);
    check_eq("t5_in_run_bit3", 32'({bus.puf_en, bus.puf_chall}), 32'h123);
    #1 rst_n = 1'b0;
    #1 check_eq("t5_async_reset", outs(), 32'h0);
    np = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.valid) np++;
    end
    check_eq("t5_no_valid", 32'(np), 32'd0);
    rst_n = 1'b1;

    // Finish first seen on the expiry cycle counts as a finish.
    set_bits(0, 8'h01);
    dly[0] = 14;
    run_req("t6", 8'h00, 0, lat, np);
    check_eq("t6_resp", 32'(bus.resp), 32'h01);
    check_eq("t6_err", 32'(bus.err), 32'h0);
    check_eq("t6_latency", 32'(lat), 32'd30);
    check_eq("t6_valid_cnt", 32'(np), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_seq.md
PUF_SEQ -- requirements
Module: puf_seq

Interface
REQ-001 SHALL have parameter RESP_W, default 8, meaning the number of response bits collected per request (1..32).
REQ-002 SHALL have parameter TIMEOUT, default 1023, meaning the maximum RUN cycles allowed per bit before abort (1..65535).
REQ-003 SHALL have port clk  input  1  meaning the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  meaning a one-cycle request to begin a response collection.
REQ-006 SHALL have port seed  input  8  meaning the first challenge, sampled when start is accepted.
REQ-007 SHALL have port puf_chall  output  8  meaning the challenge driven to the PUF bit cell.
REQ-008 SHALL have port puf_en  output  1  meaning the enable to the PUF bit cell (high only in RUN).
REQ-009 SHALL have port puf_clr  output  1  meaning the active-high clear to the PUF cell counters and arbiter (high only in CLEAR).
REQ-010 SHALL have port puf_resp  input  1  meaning the PUF cell race result.
REQ-011 SHALL have port puf_finish  input  1  meaning the PUF cell race-complete flag.
REQ-012 SHALL have port busy  output  1  meaning the sequencer is not in IDLE.
REQ-013 SHALL have port resp  output  RESP_W  meaning the collected response word.
REQ-014 SHALL have port valid  output  1  meaning a one-cycle pulse that resp is complete.
REQ-015 SHALL have port err  output  1  meaning a sticky flag that at least one bit of the last request timed out.

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, RUN, DONE.
REQ-017 IDLE: start=1 SHALL load challenge register with seed, clear bit index, timeout counter, resp and err, then enter CLEAR next cycle.
REQ-018 start SHALL be ignored in every state except IDLE.
REQ-019 CLEAR SHALL last exactly one cycle with puf_clr=1, puf_en=0, then enter RUN.
REQ-020 RUN SHALL hold puf_en=1, puf_clr=0 and increment the timeout counter each cycle.
REQ-021 In RUN, puf_finish=1 SHALL write puf_resp into resp[index] at that edge.
REQ-022 In RUN, timeout counter reaching TIMEOUT without puf_finish SHALL write 0 into resp[index] and set err.
REQ-023 puf_finish and timeout in the same cycle SHALL be treated as finish (puf_resp captured, err unchanged).
REQ-024 After each bit capture: if index = RESP_W-1 enter DONE; else increment index, increment challenge modulo 256 (8'hFF wraps to 8'h00), reset timeout counter, enter CLEAR.
REQ-025 DONE SHALL last one cycle with valid=1, then return to IDLE.
REQ-026 resp and err SHALL hold their values in IDLE until the next accepted start.
REQ-027 puf_chall SHALL equal the challenge register in all states.
REQ-028 Per-bit latency SHALL be 1 CLEAR cycle + (k+1) RUN cycles, where k is the number of RUN cycles before puf_finish is sampled high.
REQ-029 busy SHALL be 1 in CLEAR, RUN, DONE and 0 in IDLE.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE; puf_chall=0, puf_en=0, puf_clr=0, busy=0, resp=0, valid=0, err=0, index=0, timeout counter=0.
REQ-031 Reset asserted mid-request SHALL abort with no valid pulse; the request is discarded.

Structure
REQ-032 The FSM state encoding and the default RESP_W/TIMEOUT constants SHALL live in a shared package.
REQ-033 The timeout counter SHALL be a separate sub-module, puf_timeout, with clear, enable and an expired output.

Verification
REQ-034 RESP_W=8, seed=8'h3C, model finish after 5 RUN cycles with resp pattern 1,0,1,1,0,0,1,0 -> resp=8'h4D, valid pulses once 56 cycles after the start edge, err=0, puf_chall steps 3C..43.
REQ-035 seed=8'hFE, RESP_W=4 -> puf_chall sequence FE, FF, 00, 01.
REQ-036 TIMEOUT=15, finish never asserted on bit 2 -> resp[2]=0, err=1, the remaining bits captured normally, valid still pulses.
REQ-037 start pulsed during RUN with seed=8'h00 -> ignored; challenge sequence and resp unaffected.
REQ-038 rst_n low during RUN of bit 3 -> all outputs 0 immediately, no valid; a new start then completes normally.
REQ-039 puf_finish first asserted on the same cycle as the timeout expiry -> puf_resp captured, err stays 0.
